// File: rtl/lector_7_segmentos.sv
// Recovers per-digit BCD codes from a multiplexed 7-segment bus. A digit commits
// after ESTABLE identical consecutive samples and loses valido when not scanned for TIMEOUT cycles.
module lector_7_segmentos #(
   parameter int NUM_DIG = 4,
   parameter int ESTABLE = 3,
   parameter int TIMEOUT = 1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [6:0]             display,
   input  logic [NUM_DIG-1:0]     anodo,
   output logic [4*NUM_DIG-1:0]   codigo,
   output logic [NUM_DIG-1:0]     valido,
   output logic [NUM_DIG-1:0]     error,
   output logic [NUM_DIG-1:0]     actualizado,
   output logic                   error_anodo
);

   localparam int CW = $clog2(ESTABLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] EST = CW'(ESTABLE);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

   logic [6:0]         disp_s1;
   logic [NUM_DIG-1:0] anodo_s1;
   logic [6:0]         cand  [NUM_DIG];
   logic [CW-1:0]      cnt   [NUM_DIG];
   logic [TW-1:0]      timer [NUM_DIG];

   logic       multi;
   logic       single;
   logic [4:0] dec;

   // {error, code}; blank decodes to F without error, unknown glyphs to E with error.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1111110: r = 5'h00;
         7'b0110000: r = 5'h01;
         7'b1101101: r = 5'h02;
         7'b1111001: r = 5'h03;
         7'b0110011: r = 5'h04;
         7'b1011011: r = 5'h05;
         7'b1011111: r = 5'h06;
         7'b1110000: r = 5'h07;
         7'b1111111: r = 5'h08;
         7'b1111011: r = 5'h09;
         7'b0000000: r = 5'h0F;
         default:    r = 5'h1E;
      endcase
      return r;
   endfunction

   // A one-hot vector has no bit left after clearing its lowest set bit.
   assign multi  = (anodo_s1 & (anodo_s1 - NUM_DIG'(1))) != '0;
   assign single = (anodo_s1 != '0) && !multi;
   assign dec    = decode(disp_s1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp_s1     <= '0;
         anodo_s1    <= '0;
         codigo      <= '1;
         valido      <= '0;
         error       <= '0;
         actualizado <= '0;
         error_anodo <= 1'b0;
         for (int i = 0; i < NUM_DIG; i++) begin
            cand[i]  <= '0;
            cnt[i]   <= '0;
            timer[i] <= '0;
         end
      end else begin
         disp_s1     <= display;
         anodo_s1    <= anodo;
         error_anodo <= multi;
         for (int i = 0; i < NUM_DIG; i++) begin
            actualizado[i] <= 1'b0;
            if (single && anodo_s1[i]) begin
               timer[i] <= '0;
               if (disp_s1 != cand[i]) begin
                  cand[i] <= disp_s1;
                  cnt[i]  <= CW'(1);
               end else if (cnt[i] != EST) begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
               // Commit on the sample that brings the run length to exactly ESTABLE.
               if ((disp_s1 != cand[i] && ESTABLE == 1) ||
                   (disp_s1 == cand[i] && cnt[i] == EST - CW'(1))) begin
                  codigo[4*i +: 4] <= dec[3:0];
                  error[i]         <= dec[4];
                  valido[i]        <= 1'b1;
                  actualizado[i]   <= 1'b1;
               end
            end else if (timer[i] != TMO) begin
               timer[i] <= timer[i] + TW'(1);
               if (timer[i] == TMO - TW'(1)) begin
                  valido[i] <= 1'b0;
                  cnt[i]    <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lector_7_segmentos.sv
// Randomized and directed bench for lector_7_segmentos, checked against a
// sample-level reference model of digit qualification, decode and timeout.
module tb_lector_7_segmentos;

   localparam int ND  = 4;
   localparam int EST = 3;
   localparam int TMO = 1000;

   logic          clk;
   logic          rst_n;
   logic [6:0]    display;
   logic [ND-1:0] anodo;
   logic [4*ND-1:0] codigo;
   logic [ND-1:0] valido;
   logic [ND-1:0] error;
   logic [ND-1:0] actualizado;
   logic          error_anodo;

   lector_7_segmentos #(.NUM_DIG(ND), .ESTABLE(EST), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .display(display), .anodo(anodo),
      .codigo(codigo), .valido(valido), .error(error),
      .actualizado(actualizado), .error_anodo(error_anodo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: glyph table plus per-digit run length and idle time.
   logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   logic [6:0]    m_s1d;
   logic [ND-1:0] m_s1a;
   logic [6:0]    m_cand [ND];
   int            m_run  [ND];
   int            m_idle [ND];
   logic [3:0]    m_cod  [ND];
   logic [ND-1:0] m_val, m_err, m_act;
   logic          m_ea;
   int            act_seen [ND];

   task automatic model_reset();
      m_s1d = '0; m_s1a = '0; m_val = '0; m_err = '0; m_act = '0; m_ea = 1'b0;
      for (int i = 0; i < ND; i++) begin
         m_cand[i] = '0; m_run[i] = 0; m_idle[i] = 0; m_cod[i] = 4'hF;
      end
   endtask

   task automatic model_edge();
      logic [3:0] code;
      logic       bad;
      m_act = '0;
      m_ea  = ($countones(m_s1a) > 1);
      for (int i = 0; i < ND; i++) begin
         if ($countones(m_s1a) == 1 && m_s1a[i]) begin
            m_idle[i] = 0;
            if (m_s1d == m_cand[i]) m_run[i]++;
            else begin m_cand[i] = m_s1d; m_run[i] = 1; end
            if (m_run[i] == EST) begin
               code = 4'hE; bad = 1'b1;
               if (m_s1d == 7'b0) begin code = 4'hF; bad = 1'b0; end
               for (int d = 0; d < 10; d++)
                  if (m_s1d == glyph[d]) begin code = 4'(d); bad = 1'b0; end
               m_cod[i] = code; m_err[i] = bad; m_val[i] = 1'b1; m_act[i] = 1'b1;
            end
         end else if (m_idle[i] < TMO) begin
            m_idle[i]++;
            if (m_idle[i] == TMO) begin m_val[i] = 1'b0; m_run[i] = 0; end
         end
      end
   endtask

   task automatic compare_all();
      logic [4*ND-1:0] ec;
      for (int i = 0; i < ND; i++) begin
         ec[4*i +: 4] = m_cod[i];
         if (actualizado[i]) act_seen[i]++;
      end
      check("codigo", 32'(codigo), 32'(ec));
      check("valido", 32'(valido), 32'(m_val));
      check("error", 32'(error), 32'(m_err));
      check("actualizado", 32'(actualizado), 32'(m_act));
      check("error_anodo", 32'(error_anodo), 32'(m_ea));
   endtask

   task automatic step(input logic [6:0] d, input logic [ND-1:0] a);
      display = d;
      anodo   = a;
      @(posedge clk);
      model_edge();
      m_s1d = d;
      m_s1a = a;
      #1 compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) begin
         display = 7'($urandom);
         anodo   = ND'($urandom);
         @(posedge clk);
      end
      model_reset();
      #1 compare_all();
      check("rst_codigo", 32'(codigo), 32'hFFFF);
      rst_n = 1'b1;
      for (int i = 0; i < ND; i++) act_seen[i] = 0;
   endtask

   task automatic clear_seen();
      for (int i = 0; i < ND; i++) act_seen[i] = 0;
   endtask

   logic [6:0] cur [ND];
   logic [6:0] pat;
   logic [ND-1:0] a;
   int scan;

   initial begin
      rst_n = 1'b0; display = '0; anodo = '0;
      do_reset();
      repeat (3) step(7'($urandom), '0);

      // Static digit 0 showing 3, held longer than needed.
      clear_seen();
      repeat (8) step(7'b1111001, 4'b0001);
      step(7'b0, 4'b0000);
      check("static_code", 32'(codigo[3:0]), 32'h3);
      check("static_pulses", 32'(act_seen[0]), 32'd1);

      // Full scan 9,4,0,7 for three rounds.
      clear_seen();
      repeat (3) begin
         step(7'b1111011, 4'b0001);
         step(7'b0110011, 4'b0010);
         step(7'b1111110, 4'b0100);
         step(7'b1110000, 4'b1000);
      end
      step(7'b0, 4'b0000);
      check("scan_code", 32'(codigo), 32'h7049);
      check("scan_valid", 32'(valido), 32'hF);
      for (int i = 0; i < ND; i++) check("scan_pulses", 32'(act_seen[i]), 32'd1);

      // Glitch on digit 1: 5,5,6,5,5,5.
      step(7'b1011011, 4'b0010);
      step(7'b1011011, 4'b0010);
      step(7'b1011111, 4'b0010);
      step(7'b1011011, 4'b0010);
      step(7'b1011011, 4'b0010);
      check("glitch_hold", 32'(codigo[7:4]), 32'h4);
      step(7'b1011011, 4'b0010);
      step(7'b0, 4'b0000);
      check("glitch_code", 32'(codigo[7:4]), 32'h5);

      // Illegal glyph, then blank, then a double anodo.
      repeat (3) step(7'b0000001, 4'b0100);
      step(7'b0, 4'b0000);
      check("bad_code", 32'(codigo[11:8]), 32'hE);
      check("bad_err", 32'(error[2]), 32'd1);
      repeat (3) step(7'b0000000, 4'b0100);
      step(7'b0, 4'b0000);
      check("blank_code", 32'(codigo[11:8]), 32'hF);
      check("blank_err", 32'(error[2]), 32'd0);
      step(7'b1111111, 4'b0110);
      step(7'b0, 4'b0000);
      check("multi_code", 32'(codigo), 32'h7F59);

      // Timeout on digit 3 while digits 0..2 keep scanning.
      repeat (3) step(7'b1111111, 4'b1000);
      scan = 0;
      repeat (TMO + 5) begin
         step(7'b0110000, ND'(1 << scan));
         scan = (scan + 1) % 3;
      end
      check("tmo_valid", 32'(valido[3]), 32'd0);
      check("tmo_code", 32'(codigo[15:12]), 32'h8);
      step(7'b1111111, 4'b1000);
      step(7'b1111111, 4'b1000);
      step(7'b0, 4'b0000);
      check("tmo_revisit", 32'(valido[3]), 32'd0);
      step(7'b1111111, 4'b1000);
      step(7'b0, 4'b0000);
      check("tmo_revalid", 32'(valido[3]), 32'd1);

      // Randomized scanning with blanking, double anodos and pattern changes.
      do_reset();
      for (int i = 0; i < ND; i++) cur[i] = glyph[$urandom_range(0, 9)];
      scan = 0;
      repeat (3000) begin
         case ($urandom_range(0, 19))
            0: step(7'($urandom), '0);
            1: begin
               a = ND'(1 << $urandom_range(0, ND - 1));
               a = a | ND'(1 << (($urandom_range(1, ND - 1) + $clog2(a)) % ND));
               step(7'($urandom), a);
            end
            default: begin
               if ($urandom_range(0, 39) == 0) begin
                  case ($urandom_range(0, 3))
                     0: cur[scan] = 7'b0;
                     1: cur[scan] = 7'($urandom);
                     default: cur[scan] = glyph[$urandom_range(0, 9)];
                  endcase
               end
               pat = cur[scan];
               if ($urandom_range(0, 29) == 0) pat = 7'($urandom);
               step(pat, ND'(1 << scan));
               scan = (scan + 1) % ND;
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
